// File: rtl/sensor_timing_gen.sv
// Sensor timing generator: divided sensor clock plus a tick-paced frame sequencer
// (START / EXPOSE / GAP / READ) producing sst, otrig and frame bookkeeping.
module sensor_timing_gen #(
  parameter int DIV      = 8,
  parameter int CW       = 32,
  parameter int ST_LEN   = 5,
  parameter int GAP_LEN  = 88,
  parameter int READ_LEN = 286,
  parameter int FCW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           mode_cont,
  input  logic           start,
  input  logic           abort,
  input  logic [CW-1:0]  exposure,
  output logic           sclk,
  output logic           sst,
  output logic           otrig,
  output logic           busy,
  output logic           frame_done,
  output logic [FCW-1:0] frame_cnt,
  output logic [2:0]     dbg_state
);

  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_EXPOSE = 3'd2,
    S_GAP    = 3'd3,
    S_READ   = 3'd4
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] exp_lat;
  logic          pending;
  logic          tick;
  logic          go;
  logic          cnt_zero;

  assign tick      = (div_cnt == DW'(DIV - 1));
  assign go        = pending | (mode_cont & en);
  assign cnt_zero  = (cnt == '0);
  assign dbg_state = state;

  // Divider is never gated so sclk keeps running between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      sclk    <= (div_cnt < DW'(DIV / 2));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      exp_lat    <= '0;
      pending    <= 1'b0;
      sst        <= 1'b0;
      otrig      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      otrig      <= 1'b0;
      frame_done <= 1'b0;
      busy       <= (state != S_IDLE) || pending;
      if (abort) begin
        state   <= S_IDLE;
        sst     <= 1'b0;
        pending <= 1'b0;
      end else begin
        if (state == S_IDLE && start && en) pending <= 1'b1;
        // Every phase change waits for a tick; the counter runs down to zero first.
        if (tick) begin
          unique case (state)
            S_IDLE: begin
              if (go) begin
                state   <= S_START;
                sst     <= 1'b1;
                cnt     <= CW'(ST_LEN);
                exp_lat <= exposure;
                pending <= 1'b0;
              end
            end
            S_START: begin
              if (!cnt_zero) cnt <= cnt - 1'b1;
              else begin
                state <= S_EXPOSE;
                cnt   <= exp_lat;
              end
            end
            S_EXPOSE: begin
              if (!cnt_zero) cnt <= cnt - 1'b1;
              else begin
                state <= S_GAP;
                sst   <= 1'b0;
                cnt   <= CW'(GAP_LEN);
              end
            end
            S_GAP: begin
              if (!cnt_zero) cnt <= cnt - 1'b1;
              else begin
                state <= S_READ;
                otrig <= 1'b1;
                cnt   <= CW'(READ_LEN);
              end
            end
            S_READ: begin
              if (!cnt_zero) cnt <= cnt - 1'b1;
              else begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
                // Back-to-back frames skip IDLE so sst rises alongside frame_done.
                if (mode_cont && en) begin
                  state   <= S_START;
                  sst     <= 1'b1;
                  cnt     <= CW'(ST_LEN);
                  exp_lat <= exposure;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_timing_gen.sv
// Directed bench for sensor_timing_gen: a default-parameter instance and a small
// DIV=2 / FCW=2 instance, each checked against hand-computed timings.
module tb_sensor_timing_gen;

  localparam int CW = 32;

  localparam int D_SST   = 0;
  localparam int D_OTRIG = 1;
  localparam int D_FDONE = 2;
  localparam int S_SST   = 3;
  localparam int S_OTRIG = 4;
  localparam int S_FDONE = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Default-parameter instance
  logic          d_reset = 1'b0, d_en = 1'b0, d_mode = 1'b0, d_start = 1'b0, d_abort = 1'b0;
  logic [CW-1:0] d_exp = '0;
  logic          d_sclk, d_sst, d_otrig, d_busy, d_frame_done;
  logic [15:0]   d_frame_cnt;
  logic [2:0]    d_state;

  // Small instance: DIV=2, FCW=2, short phases
  logic          s_reset = 1'b0, s_en = 1'b0, s_mode = 1'b0, s_start = 1'b0, s_abort = 1'b0;
  logic [CW-1:0] s_exp = '0;
  logic          s_sclk, s_sst, s_otrig, s_busy, s_frame_done;
  logic [1:0]    s_frame_cnt;
  logic [2:0]    s_state;

  sensor_timing_gen u_d (
    .clk(clk), .reset(d_reset), .en(d_en), .mode_cont(d_mode), .start(d_start),
    .abort(d_abort), .exposure(d_exp), .sclk(d_sclk), .sst(d_sst), .otrig(d_otrig),
    .busy(d_busy), .frame_done(d_frame_done), .frame_cnt(d_frame_cnt), .dbg_state(d_state)
  );

  sensor_timing_gen #(
    .DIV(2), .CW(CW), .ST_LEN(1), .GAP_LEN(2), .READ_LEN(3), .FCW(2)
  ) u_s (
    .clk(clk), .reset(s_reset), .en(s_en), .mode_cont(s_mode), .start(s_start),
    .abort(s_abort), .exposure(s_exp), .sclk(s_sclk), .sst(s_sst), .otrig(s_otrig),
    .busy(s_busy), .frame_done(s_frame_done), .frame_cnt(s_frame_cnt), .dbg_state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int id);
    case (id)
      D_SST:   return d_sst;
      D_OTRIG: return d_otrig;
      D_FDONE: return d_frame_done;
      S_SST:   return s_sst;
      S_OTRIG: return s_otrig;
      S_FDONE: return s_frame_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int id, input logic val, input int max_cyc, input string tag);
    int n = 0;
    while (sig(id) !== val && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(sig(id) === val), 32'd1);
  endtask

  task automatic watch_none(input int id, input int ncyc, input string tag);
    int seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (sig(id) === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int t0, t1, t2, seen;

    // Reset: async assertion clears every output before any clock edge
    #2;
    d_reset = 1'b1;
    s_reset = 1'b1;
    #1;
    chk("rst_d_outs", 32'({d_sclk, d_sst, d_otrig, d_busy, d_frame_done}), 32'd0);
    chk("rst_d_fcnt", 32'(d_frame_cnt), 32'd0);
    chk("rst_s_outs", 32'({s_sclk, s_sst, s_otrig, s_busy, s_frame_done}), 32'd0);
    chk("rst_s_fcnt", 32'(s_frame_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Release reset with a start request already on the default instance
    d_reset = 1'b0;
    s_reset = 1'b0;
    d_en    = 1'b1;
    d_exp   = 32'd10;
    d_start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) d_start = 1'b0;
      chk($sformatf("d_sclk%0d", k), 32'(((k - 1) % 8) < 4), 32'(d_sclk));
      chk($sformatf("s_sclk%0d", k), 32'(s_sclk), 32'(k % 2));
      chk($sformatf("d_sst_lat%0d", k), 32'(d_sst), 32'(k == 8));
      chk($sformatf("d_busy%0d", k), 32'(d_busy), 32'(k >= 2));
    end

    // Single-shot frame, exposure=10
    t0 = cyc;
    wait_for(D_SST, 1'b0, 200, "a_sst_fall");
    chk("a_sst_high", 32'(cyc - t0), 32'd136);
    t1 = cyc;
    wait_for(D_OTRIG, 1'b1, 1000, "a_otrig");
    chk("a_gap", 32'(cyc - t1), 32'd712);
    chk("a_fcnt_mid", 32'(d_frame_cnt), 32'd0);
    t2 = cyc;
    wait_for(D_OTRIG, 1'b0, 5, "a_otrig_fall");
    chk("a_otrig_width", 32'(cyc - t2), 32'd1);
    wait_for(D_FDONE, 1'b1, 3000, "a_fdone");
    chk("a_read", 32'(cyc - t2), 32'd2296);
    chk("a_fcnt", 32'(d_frame_cnt), 32'd1);
    t1 = cyc;
    wait_for(D_FDONE, 1'b0, 5, "a_fdone_fall");
    chk("a_fdone_width", 32'(cyc - t1), 32'd1);
    repeat (2) @(negedge clk);
    chk("a_busy_after", 32'(d_busy), 32'd0);
    chk("a_state_after", 32'(d_state), 32'd0);

    // Continuous mode, exposure 3 then 7 during the first EXPOSE
    d_exp  = 32'd3;
    d_mode = 1'b1;
    wait_for(D_SST, 1'b1, 20, "b_sst1_rise");
    t0 = cyc;
    repeat (60) @(negedge clk);
    chk("b_state_expose", 32'(d_state), 32'd2);
    d_exp = 32'd7;
    wait_for(D_SST, 1'b0, 100, "b_sst1_fall");
    chk("b_sst1_high", 32'(cyc - t0), 32'd80);
    t1 = cyc;
    wait_for(D_FDONE, 1'b1, 4000, "b_fdone");
    chk("b_frame_tail", 32'(cyc - t1), 32'd3008);
    chk("b_sst2_with_done", 32'(d_sst), 32'd1);
    chk("b_fcnt", 32'(d_frame_cnt), 32'd2);
    t2 = cyc;
    wait_for(D_SST, 1'b0, 200, "b_sst2_fall");
    chk("b_sst2_high", 32'(cyc - t2), 32'd112);

    // Abort during GAP of the second frame
    d_mode = 1'b0;
    repeat (100) @(negedge clk);
    chk("c_state_gap", 32'(d_state), 32'd3);
    d_abort = 1'b1;
    @(negedge clk);
    d_abort = 1'b0;
    chk("c_state_idle", 32'(d_state), 32'd0);
    chk("c_sst", 32'(d_sst), 32'd0);
    chk("c_otrig", 32'(d_otrig), 32'd0);
    seen = 0;
    repeat (3000) begin
      @(negedge clk);
      if (d_otrig === 1'b1 || d_frame_done === 1'b1) seen++;
    end
    chk("c_no_pulses", 32'(seen), 32'd0);
    chk("c_fcnt", 32'(d_frame_cnt), 32'd2);
    chk("c_busy", 32'(d_busy), 32'd0);

    // Small instance: single shot with a start during READ
    s_en  = 1'b1;
    s_exp = 32'd2;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    wait_for(S_SST, 1'b1, 10, "e_sst_rise");
    t0 = cyc;
    wait_for(S_SST, 1'b0, 30, "e_sst_fall");
    chk("e_sst_high", 32'(cyc - t0), 32'd10);
    t1 = cyc;
    wait_for(S_OTRIG, 1'b1, 30, "e_otrig");
    chk("e_gap", 32'(cyc - t1), 32'd6);
    t2 = cyc;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    wait_for(S_FDONE, 1'b1, 30, "e_fdone");
    chk("e_read", 32'(cyc - t2), 32'd8);
    chk("e_fcnt", 32'(s_frame_cnt), 32'd1);
    watch_none(S_SST, 20, "e_start_in_read_ignored");
    chk("e_busy", 32'(s_busy), 32'd0);

    // Start and abort in the same cycle: abort wins
    s_start = 1'b1;
    s_abort = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_abort = 1'b0;
    watch_none(S_SST, 10, "f_no_start");
    chk("f_state", 32'(s_state), 32'd0);
    chk("f_busy", 32'(s_busy), 32'd0);

    // Three more frames wrap the 2-bit frame counter 3 -> 0
    for (int i = 0; i < 3; i++) begin
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      wait_for(S_FDONE, 1'b1, 60, $sformatf("g_fdone%0d", i));
      chk($sformatf("g_fcnt%0d", i), 32'(s_frame_cnt), 32'((i + 2) % 4));
      @(negedge clk);
    end

    // Continuous mode with en dropped during EXPOSE
    s_mode = 1'b1;
    wait_for(S_SST, 1'b1, 10, "h_sst_rise");
    repeat (5) @(negedge clk);
    chk("h_state_expose", 32'(s_state), 32'd2);
    s_en = 1'b0;
    wait_for(S_FDONE, 1'b1, 60, "h_fdone");
    chk("h_fcnt", 32'(s_frame_cnt), 32'd1);
    watch_none(S_SST, 20, "h_no_next_frame");
    chk("h_state_idle", 32'(s_state), 32'd0);
    s_mode = 1'b0;

    // Reset mid-EXPOSE on the default instance
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    wait_for(D_SST, 1'b1, 20, "i_sst_rise");
    repeat (60) @(negedge clk);
    chk("i_state_expose", 32'(d_state), 32'd2);
    #2;
    d_reset = 1'b1;
    #1;
    chk("i_rst_outs", 32'({d_sclk, d_sst, d_otrig, d_busy, d_frame_done}), 32'd0);
    chk("i_rst_fcnt", 32'(d_frame_cnt), 32'd0);
    chk("i_rst_state", 32'(d_state), 32'd0);
    @(negedge clk);
    d_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_timing_gen.md
SENSOR_TIMING_GEN -- requirements
Module: sensor_timing_gen

Interface
REQ-001 Parameter DIV, default 8: clk cycles per sensor clock period; even, >= 2.
REQ-002 Parameter CW, default 32: width of the exposure input and the phase counter.
REQ-003 Parameter ST_LEN, default 5: START phase lasts ST_LEN+1 ticks.
REQ-004 Parameter GAP_LEN, default 88: GAP phase lasts GAP_LEN+1 ticks.
REQ-005 Parameter READ_LEN, default 286: READ phase lasts READ_LEN+1 ticks.
REQ-006 Parameter FCW, default 16: frame counter width.
REQ-007 Port clk  in  1: single system clock, rising edge.
REQ-008 Port reset  in  1: asynchronous, active-high reset.
REQ-009 Port en  in  1: permits new frames to start.
REQ-010 Port mode_cont  in  1: 1 = continuous back-to-back frames, 0 = single-shot on start.
REQ-011 Port start  in  1: single-cycle frame request.
REQ-012 Port abort  in  1: terminates the frame in progress.
REQ-013 Port exposure  in  CW: EXPOSE phase length minus one, in ticks.
REQ-014 Port sclk  out  1: sensor clock, registered.
REQ-015 Port sst  out  1: sensor start/integrate, registered.
REQ-016 Port otrig  out  1: one-cycle readout trigger, registered.
REQ-017 Port busy  out  1: high while a frame is pending or active.
REQ-018 Port frame_done  out  1: one-cycle pulse at frame completion.
REQ-019 Port frame_cnt  out  FCW: completed-frame count, wraps modulo 2^FCW.

Function
REQ-020 Divider: free-running 0..DIV-1, never gated; tick = one-cycle flag when divider = DIV-1.
REQ-021 sclk: high while divider < DIV/2, low otherwise; one cycle of register latency.
REQ-022 States: IDLE, START, EXPOSE, GAP, READ; all state changes occur only on tick, except abort and reset.
REQ-023 Phase counter behaviour: loaded on phase entry; decrements on each tick while nonzero; phase exits on the tick where it is zero.
REQ-024 Start capture: start in IDLE with en=1 sets the pending flag.
REQ-025 Pending in continuous mode: mode_cont=1 with en=1 in IDLE acts as pending.
REQ-026 Start while busy: ignored and not queued.
REQ-027 IDLE->START (tick with pending): sst<=1; counter<=ST_LEN; exposure latched into an internal register; pending cleared.
REQ-028 START->EXPOSE: counter<=latched exposure; exposure changes mid-frame have no effect until the next frame; exposure=0 gives an EXPOSE phase of 1 tick.
REQ-029 EXPOSE->GAP: sst<=0; counter<=GAP_LEN.
REQ-030 GAP->READ: otrig high for exactly one clk cycle; counter<=READ_LEN.
REQ-031 READ exit, common actions: frame_done pulses one cycle; frame_cnt increments.
REQ-032 READ exit, next state: if mode_cont=1 and en=1, go directly to START on the same tick (sst rises the same cycle frame_done pulses, exposure re-latched); otherwise go to IDLE.
REQ-033 Abort: highest priority, any state; next cycle state=IDLE, sst=0, otrig=0, pending cleared, no frame_done, frame_cnt unchanged.
REQ-034 Simultaneous start and abort: abort wins; pending not set.
REQ-035 en deasserted mid-frame: the current frame completes normally; no further frame starts.
REQ-036 busy = (state != IDLE) or pending, registered.

Reset
REQ-037 Asynchronous reset clears: divider, counter, pending, frame_cnt and the exposure latch to 0; state to IDLE; sclk, sst, otrig, busy and frame_done to 0.
REQ-038 Reset asserted mid-frame aborts the frame immediately, with no otrig or frame_done pulse.
REQ-039 After reset release, the first tick occurs DIV cycles later.

Verification
REQ-040 Reset check: assert reset at an arbitrary point, including mid-EXPOSE -> all outputs 0 and frame_cnt=0 within the same cycle, before the next clk edge.
REQ-041 Single-shot frame (defaults, exposure=10, start pulse) -> sst high 136 clk cycles; otrig 712 cycles after sst falls; frame_done 2296 cycles after otrig; frame_cnt=1; busy=0 afterwards.
REQ-042 Continuous mode (exposure=3, exposure changed to 7 during the first EXPOSE) -> first frame sst high 80 cycles, second 112; second sst rises in the frame_done cycle.
REQ-043 Abort during GAP -> sst=0 and IDLE next cycle; no otrig, no frame_done; frame_cnt unchanged.
REQ-044 Priority and wrap (FCW=2) -> start during READ ignored; start+abort in the same cycle leaves IDLE; four completed frames wrap frame_cnt 3->0.
REQ-045 en and DIV=2 -> en dropped during EXPOSE in continuous mode: the frame finishes, then IDLE; with DIV=2, sclk toggles every cycle and phase timings scale to 2 cycles per tick.
